exe_mem_issue: RTL and testbench

- Execute stage directly upstream of the MEM stage.
- Latches one instruction from ID and computes a simple ALU result or load/store address.
- Issues the data SRAM request using a req/addr_ok handshake, and checks access alignment.
- Drives the MEM-stage bundle: rf collect, pc, load-type bus and exception bus.

---
 rtl/exe_mem_issue.sv | 213 +++++++++++++++++++++
 tb/tb_exe_mem_issue.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_mem_issue.sv
// Execute stage feeding MEM: ALU, address generation, alignment check
// and data SRAM request issue over a req/addr_ok handshake.
module exe_mem_issue #(
    parameter int EXC_WID = 7
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ds_to_es_valid,
    output logic               es_allowin,
    input  logic [31:0]        ds_pc,
    input  logic [31:0]        ds_src1,
    input  logic [31:0]        ds_src2,
    input  logic [2:0]         ds_alu_op,
    input  logic [7:0]         ds_mem_op,
    input  logic [31:0]        ds_st_data,
    input  logic               ds_rf_we,
    input  logic [4:0]         ds_rf_waddr,
    input  logic [EXC_WID-1:0] ds_except,
    input  logic               ms_allowin,
    output logic               es_to_ms_valid,
    output logic [38:0]        es_rf_collect,
    output logic [31:0]        es_pc,
    output logic [4:0]         mem_inst_bus,
    output logic [EXC_WID-1:0] es_to_ms_bus,
    input  logic               except_flush,
    input  logic               ms_ex,
    input  logic               wb_ex,
    output logic               data_sram_req,
    output logic               data_sram_wr,
    output logic [1:0]         data_sram_size,
    output logic [3:0]         data_sram_wstrb,
    output logic [31:0]        data_sram_addr,
    output logic [31:0]        data_sram_wdata,
    input  logic               data_sram_addr_ok,
    output logic               es_cancel_dataok
);
    typedef enum logic [1:0] {IDLE, WAIT_ADDR, DONE} state_t;

    state_t state, state_nx;

    logic               es_valid;
    logic               cancel;
    logic [31:0]        pc, src1, src2, st_data;
    logic [2:0]         alu_op;
    logic [7:0]         mem_op;
    logic               rf_we;
    logic [4:0]         rf_waddr;
    logic [EXC_WID-1:0] except;

    logic [31:0] q_addr, q_wdata;
    logic        q_wr;
    logic [1:0]  q_size;
    logic [3:0]  q_wstrb;

    logic ld_w, ld_h, ld_hu, ld_b, ld_bu, st_w, st_h, st_b;
    logic is_load, is_store, is_mem, ale;
    logic need_req, cancel_now, es_ready_go;
    logic [31:0] addr, alu_res, wdata;
    logic [1:0]  size;
    logic [3:0]  wstrb;

    assign {ld_w, ld_h, ld_hu, ld_b, ld_bu, st_w, st_h, st_b} = mem_op;

    assign is_load  = ld_w | ld_h | ld_hu | ld_b | ld_bu;
    assign is_store = st_w | st_h | st_b;
    assign is_mem   = is_load | is_store;
    assign addr     = src1 + src2;

    always_comb begin
        alu_res = src2;
        unique case (alu_op)
            3'd0:    alu_res = src1 + src2;
            3'd1:    alu_res = src1 - src2;
            3'd2:    alu_res = src1 & src2;
            3'd3:    alu_res = src1 | src2;
            3'd4:    alu_res = src1 ^ src2;
            3'd5:    alu_res = {31'd0, $signed(src1) < $signed(src2)};
            3'd6:    alu_res = {31'd0, src1 < src2};
            default: alu_res = src2;
        endcase
    end

    always_comb begin
        size  = 2'd0;
        wstrb = 4'b0000;
        wdata = st_data;
        unique case (1'b1)
            st_w: begin
                size  = 2'd2;
                wstrb = 4'b1111;
            end
            st_h: begin
                size  = 2'd1;
                wstrb = addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{st_data[15:0]}};
            end
            st_b: begin
                wstrb = 4'b0001 << addr[1:0];
                wdata = {4{st_data[7:0]}};
            end
            default: ;
        endcase
        if (ld_w)
            size = 2'd2;
        else if (ld_h | ld_hu)
            size = 2'd1;
    end

    assign ale = ((ld_w | st_w) & (addr[1:0] != 2'b00))
               | ((ld_h | ld_hu | st_h) & addr[0]);

    assign need_req = es_valid & is_mem & ~ale & ~(|except)
                    & ~ms_ex & ~wb_ex & ~except_flush;

    assign cancel_now = cancel | except_flush;

    always_comb begin
        state_nx         = state;
        data_sram_req    = 1'b0;
        es_ready_go      = 1'b1;
        es_cancel_dataok = 1'b0;
        unique case (state)
            IDLE: begin
                data_sram_req = need_req;
                es_ready_go   = ~need_req | data_sram_addr_ok;
                if (need_req & data_sram_addr_ok)
                    state_nx = ms_allowin ? IDLE : DONE;
                else if (need_req)
                    state_nx = WAIT_ADDR;
            end
            WAIT_ADDR: begin
                // A killed request still has to complete its handshake
                data_sram_req = 1'b1;
                es_ready_go   = data_sram_addr_ok & ~cancel_now;
                if (data_sram_addr_ok) begin
                    es_cancel_dataok = cancel_now;
                    state_nx = (cancel_now | ms_allowin) ? IDLE : DONE;
                end
            end
            DONE: begin
                if ((es_valid & ms_allowin) | except_flush)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign es_to_ms_valid = es_valid & es_ready_go;
    assign es_allowin = (~es_valid & (state != WAIT_ADDR))
                      | (es_valid & es_ready_go & ms_allowin);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            es_valid <= 1'b0;
            cancel   <= 1'b0;
            pc       <= '0;
            src1     <= '0;
            src2     <= '0;
            st_data  <= '0;
            alu_op   <= '0;
            mem_op   <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            except   <= '0;
            q_addr   <= '0;
            q_wdata  <= '0;
            q_wr     <= 1'b0;
            q_size   <= '0;
            q_wstrb  <= '0;
        end else begin
            state <= state_nx;
            if (except_flush)
                es_valid <= 1'b0;
            else if (es_allowin)
                es_valid <= ds_to_es_valid;
            if (ds_to_es_valid & es_allowin & ~except_flush) begin
                pc       <= ds_pc;
                src1     <= ds_src1;
                src2     <= ds_src2;
                st_data  <= ds_st_data;
                alu_op   <= ds_alu_op;
                mem_op   <= ds_mem_op;
                rf_we    <= ds_rf_we;
                rf_waddr <= ds_rf_waddr;
                except   <= ds_except;
            end
            if (state == WAIT_ADDR)
                cancel <= cancel_now & ~data_sram_addr_ok;
            else
                cancel <= 1'b0;
            if (state == IDLE) begin
                q_addr  <= addr;
                q_wdata <= wdata;
                q_wr    <= is_store;
                q_size  <= size;
                q_wstrb <= wstrb;
            end
        end
    end

    assign data_sram_addr  = (state == WAIT_ADDR) ? q_addr  : addr;
    assign data_sram_wdata = (state == WAIT_ADDR) ? q_wdata : wdata;
    assign data_sram_wr    = (state == WAIT_ADDR) ? q_wr    : is_store;
    assign data_sram_size  = (state == WAIT_ADDR) ? q_size  : size;
    assign data_sram_wstrb = (state == WAIT_ADDR) ? q_wstrb : wstrb;

    assign es_rf_collect = {is_load, rf_we & es_valid, rf_waddr,
                            is_mem ? addr : alu_res};
    assign es_pc         = pc;
    assign mem_inst_bus  = mem_op[7:3];
    assign es_to_ms_bus  = except | {{(EXC_WID-1){1'b0}}, ale};
endmodule

// File: tb/tb_exe_mem_issue.sv
// Directed bench for exe_mem_issue with a behavioural reference model.
module tb_exe_mem_issue;
    logic        clk = 1'b0;
    logic        reset;
    logic        ds_to_es_valid;
    logic        es_allowin;
    logic [31:0] ds_pc, ds_src1, ds_src2, ds_st_data;
    logic [2:0]  ds_alu_op;
    logic [7:0]  ds_mem_op;
    logic        ds_rf_we;
    logic [4:0]  ds_rf_waddr;
    logic [6:0]  ds_except;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [38:0] es_rf_collect;
    logic [31:0] es_pc;
    logic [4:0]  mem_inst_bus;
    logic [6:0]  es_to_ms_bus;
    logic        except_flush, ms_ex, wb_ex;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        es_cancel_dataok;

    exe_mem_issue #(.EXC_WID(7)) dut (
        .clk(clk), .reset(reset),
        .ds_to_es_valid(ds_to_es_valid), .es_allowin(es_allowin),
        .ds_pc(ds_pc), .ds_src1(ds_src1), .ds_src2(ds_src2),
        .ds_alu_op(ds_alu_op), .ds_mem_op(ds_mem_op),
        .ds_st_data(ds_st_data), .ds_rf_we(ds_rf_we),
        .ds_rf_waddr(ds_rf_waddr), .ds_except(ds_except),
        .ms_allowin(ms_allowin), .es_to_ms_valid(es_to_ms_valid),
        .es_rf_collect(es_rf_collect), .es_pc(es_pc),
        .mem_inst_bus(mem_inst_bus), .es_to_ms_bus(es_to_ms_bus),
        .except_flush(except_flush), .ms_ex(ms_ex), .wb_ex(wb_ex),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size),
        .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok),
        .es_cancel_dataok(es_cancel_dataok)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] addr;
        logic        ale;
        logic        ld;
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [4:0]  ldbus;
    } exp_t;

    int checks = 0;
    int errors = 0;
    int hs = 0;
    exp_t cur;
    logic [31:0] cur_pc;
    logic [4:0]  cur_waddr;
    logic        cur_we;
    logic [6:0]  cur_exc;
    logic [31:0] pc_ctr = 32'h0000_0100;
    logic [31:0] first_addr, first_wdata;
    logic [3:0]  first_wstrb;
    logic [1:0]  first_size;

    function automatic exp_t model(input logic [2:0] op, input logic [7:0] m,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] d);
        exp_t e;
        int n;
        e = '0;
        e.addr = a + b;
        case (op)
            3'd0: e.result = a + b;
            3'd1: e.result = a - b;
            3'd2: e.result = a & b;
            3'd3: e.result = a | b;
            3'd4: e.result = a ^ b;
            3'd5: e.result = (signed'(a) < signed'(b)) ? 32'd1 : 32'd0;
            3'd6: e.result = ({1'b0, a} < {1'b0, b}) ? 32'd1 : 32'd0;
            default: e.result = b;
        endcase
        // access width in bytes
        n = (m[7] | m[2]) ? 4 : (m[6] | m[5] | m[1]) ? 2 : 1;
        e.ld = |m[7:3];
        e.wr = |m[2:0];
        e.ldbus = m[7:3];
        if (m != 8'd0) begin
            e.result = e.addr;
            e.ale = (e.addr % n) != 0;
        end
        e.size = (n == 4) ? 2'd2 : (n == 2) ? 2'd1 : 2'd0;
        if (e.wr) e.wstrb = 4'(((1 << n) - 1) << (e.addr % 4));
        for (int k = 0; k < 4; k++) e.wdata[8*k +: 8] = d[8*(k % n) +: 8];
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison of DUT outputs against the model
    task automatic scoreboard();
        if (es_to_ms_valid) begin
            chk("sb_collect", 64'(es_rf_collect),
                64'({cur.ld, cur_we, cur_waddr, cur.result}));
            chk("sb_pc", 64'(es_pc), 64'(cur_pc));
            chk("sb_exc", 64'(es_to_ms_bus), 64'(cur_exc | {6'd0, cur.ale}));
            chk("sb_ldbus", 64'(mem_inst_bus), 64'(cur.ldbus));
        end
        if (data_sram_req) begin
            chk("sb_addr", 64'(data_sram_addr), 64'(cur.addr));
            chk("sb_wr", 64'(data_sram_wr), 64'(cur.wr));
            chk("sb_size", 64'(data_sram_size), 64'(cur.size));
            chk("sb_wstrb", 64'(data_sram_wstrb), 64'(cur.wstrb));
            if (cur.wr) chk("sb_wdata", 64'(data_sram_wdata), 64'(cur.wdata));
            if (data_sram_addr_ok) hs++;
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [7:0] m,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] d, input logic [6:0] exc);
        ds_alu_op = op; ds_mem_op = m;
        ds_src1 = a; ds_src2 = b; ds_st_data = d;
        ds_pc = pc_ctr; ds_rf_waddr = pc_ctr[6:2]; ds_rf_we = pc_ctr[2];
        ds_except = exc;
        ds_to_es_valid = 1'b1;
        cur = model(op, m, a, b, d);
        cur_pc = pc_ctr; cur_waddr = pc_ctr[6:2]; cur_we = pc_ctr[2];
        cur_exc = exc;
        pc_ctr = pc_ctr + 32'd4;
        @(negedge clk);
        scoreboard();
        chk("issue_allowin", 64'(es_allowin), 64'd1);
        @(posedge clk); #1;
        ds_to_es_valid = 1'b0;
    endtask

    // Serve addr_ok after lat request cycles; hold ms_allowin low hold cycles
    task automatic run(input int lat, input int hold, output int reqs,
                       output int at, output logic [38:0] col,
                       output logic [6:0] bus);
        reqs = 0; at = -1; col = '0; bus = '0;
        first_addr = '0; first_wdata = '0; first_wstrb = '0; first_size = '0;
        for (int i = 0; i < 20 && at < 0; i++) begin
            data_sram_addr_ok = (reqs >= lat);
            ms_allowin = (i >= hold);
            @(negedge clk);
            scoreboard();
            if (data_sram_req) begin
                if (reqs == 0) begin
                    first_addr = data_sram_addr; first_wdata = data_sram_wdata;
                    first_wstrb = data_sram_wstrb; first_size = data_sram_size;
                end
                reqs++;
            end
            if (es_to_ms_valid && ms_allowin) begin
                at = i; col = es_rf_collect; bus = es_to_ms_bus;
            end
            @(posedge clk); #1;
        end
        data_sram_addr_ok = 1'b0;
        ms_allowin = 1'b1;
        if (at < 0) begin
            checks++; errors++;
            $display("FAIL run_timeout: got no forward expected forward");
        end
    endtask

    logic [2:0]  alu_ops [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [31:0] alu_a   [8] = '{32'hFFFF_FFFF, 32'd5, 32'hF0F0_F0F0,
                                 32'hF000_0000, 32'hAAAA_AAAA, 32'hFFFF_FFFF,
                                 32'hFFFF_FFFF, 32'd0};
    logic [31:0] alu_b   [8] = '{32'd1, 32'd7, 32'h0FF0_0FF0, 32'h0000_000F,
                                 32'hFFFF_FFFF, 32'd1, 32'd1, 32'h1234_5678};
    logic [31:0] alu_e   [8] = '{32'd0, 32'hFFFF_FFFE, 32'h00F0_00F0,
                                 32'hF000_000F, 32'h5555_5555, 32'd1, 32'd0,
                                 32'h1234_5678};

    initial begin
        int reqs, at, h0;
        logic [38:0] col;
        logic [6:0] bus;
        reset = 1'b1;
        ds_to_es_valid = 0; ds_pc = 0; ds_src1 = 0; ds_src2 = 0;
        ds_st_data = 0; ds_alu_op = 0; ds_mem_op = 0; ds_rf_we = 0;
        ds_rf_waddr = 0; ds_except = 0; ms_allowin = 1; except_flush = 0;
        ms_ex = 0; wb_ex = 0; data_sram_addr_ok = 0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_req", 64'(data_sram_req), 64'd0);
        chk("rst_valid", 64'(es_to_ms_valid), 64'd0);
        chk("rst_cancel", 64'(es_cancel_dataok), 64'd0);
        chk("rst_allowin", 64'(es_allowin), 64'd1);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            issue(alu_ops[i], 8'h00, alu_a[i], alu_b[i], 32'd0, 7'd0);
            run(0, 0, reqs, at, col, bus);
            chk("alu_result", 64'(col[31:0]), 64'(alu_e[i]));
            chk("alu_latency", 64'(at), 64'd0);
            chk("alu_noreq", 64'(reqs), 64'd0);
        end

        issue(3'd0, 8'h00, 32'd2, 32'd3, 32'd0, 7'b0000100);
        run(0, 0, reqs, at, col, bus);
        chk("exc_pass", 64'(bus), 64'h04);

        // st_h with two-cycle addr_ok stall
        h0 = hs;
        issue(3'd0, 8'h02, 32'h1000, 32'd2, 32'h0000_ABCD, 7'd0);
        run(2, 0, reqs, at, col, bus);
        chk("sth_reqs", 64'(reqs), 64'd3);
        chk("sth_fwd_at", 64'(at), 64'd2);
        chk("sth_addr", 64'(first_addr), 64'h1002);
        chk("sth_size", 64'(first_size), 64'd1);
        chk("sth_wstrb", 64'(first_wstrb), 64'b1100);
        chk("sth_wdata", 64'(first_wdata), 64'hABCD_ABCD);
        chk("sth_hs", 64'(hs - h0), 64'd1);

        issue(3'd0, 8'h80, 32'h1000, 32'd1, 32'd0, 7'd0);
        run(0, 0, reqs, at, col, bus);
        chk("ale_ldw_reqs", 64'(reqs), 64'd0);
        chk("ale_ldw_at", 64'(at), 64'd0);
        chk("ale_ldw_bus", 64'(bus[0]), 64'd1);
        chk("ale_ldw_frommem", 64'(col[38]), 64'd1);

        issue(3'd0, 8'h40, 32'h6000, 32'd3, 32'd0, 7'd0);
        run(0, 0, reqs, at, col, bus);
        chk("ale_ldh_reqs", 64'(reqs), 64'd0);
        chk("ale_ldh_bus", 64'(bus[0]), 64'd1);

        // ld_b killed by flush while waiting for addr_ok
        issue(3'd0, 8'h10, 32'h2000, 32'd3, 32'd0, 7'd0);
        data_sram_addr_ok = 1'b0;
        @(negedge clk); scoreboard();
        chk("fl_req0", 64'(data_sram_req), 64'd1);
        @(posedge clk); #1;
        except_flush = 1'b1;
        @(negedge clk); scoreboard();
        chk("fl_req1", 64'(data_sram_req), 64'd1);
        chk("fl_addr1", 64'(data_sram_addr), 64'h2003);
        chk("fl_valid1", 64'(es_to_ms_valid), 64'd0);
        @(posedge clk); #1;
        except_flush = 1'b0;
        data_sram_addr_ok = 1'b1;
        @(negedge clk); scoreboard();
        chk("fl_req2", 64'(data_sram_req), 64'd1);
        chk("fl_addr2", 64'(data_sram_addr), 64'h2003);
        chk("fl_cancel2", 64'(es_cancel_dataok), 64'd1);
        chk("fl_valid2", 64'(es_to_ms_valid), 64'd0);
        chk("fl_allowin2", 64'(es_allowin), 64'd0);
        @(posedge clk); #1;
        data_sram_addr_ok = 1'b0;
        @(negedge clk); scoreboard();
        chk("fl_cancel3", 64'(es_cancel_dataok), 64'd0);
        chk("fl_req3", 64'(data_sram_req), 64'd0);
        chk("fl_valid3", 64'(es_to_ms_valid), 64'd0);
        chk("fl_allowin3", 64'(es_allowin), 64'd1);
        @(posedge clk); #1;

        // st_w accepted while MEM is blocked for four cycles
        h0 = hs;
        issue(3'd0, 8'h04, 32'h5000, 32'd8, 32'hDEAD_BEEF, 7'd0);
        run(0, 4, reqs, at, col, bus);
        chk("hold_reqs", 64'(reqs), 64'd1);
        chk("hold_hs", 64'(hs - h0), 64'd1);
        chk("hold_at", 64'(at), 64'd4);
        chk("hold_addr", 64'(first_addr), 64'h5008);
        chk("hold_wstrb", 64'(first_wstrb), 64'hF);
        chk("hold_result", 64'(col[31:0]), 64'h5008);

        // async reset while waiting for addr_ok
        issue(3'd0, 8'h04, 32'h3000, 32'd0, 32'h1122_3344, 7'd0);
        data_sram_addr_ok = 1'b0;
        @(negedge clk); scoreboard();
        chk("ar_req0", 64'(data_sram_req), 64'd1);
        @(posedge clk); #1;
        @(negedge clk); scoreboard();
        chk("ar_req1", 64'(data_sram_req), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("ar_req_drop", 64'(data_sram_req), 64'd0);
        chk("ar_valid", 64'(es_to_ms_valid), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("ar_allowin", 64'(es_allowin), 64'd1);
        chk("ar_req_idle", 64'(data_sram_req), 64'd0);
        @(posedge clk); #1;

        issue(3'd0, 8'h01, 32'h4000, 32'd1, 32'h0000_00A5, 7'd0);
        run(0, 0, reqs, at, col, bus);
        chk("stb_reqs", 64'(reqs), 64'd1);
        chk("stb_at", 64'(at), 64'd0);
        chk("stb_wstrb", 64'(first_wstrb), 64'b0010);
        chk("stb_wdata", 64'(first_wdata), 64'hA5A5_A5A5);
        chk("stb_size", 64'(first_size), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
